// File: rtl/battleship_pkg.sv
// Shared constants for the Battleship game flow: board geometry, cell codes,
// PS/2 scancodes, shot result codes and the shot sequencer state encoding.
package battleship_pkg;

  localparam int BOARD_SIZE = 10;
  localparam int SHIP_CELLS = 17;

  localparam logic [1:0] CELL_WATER = 2'b00;
  localparam logic [1:0] CELL_SHIP  = 2'b01;
  localparam logic [1:0] CELL_MISS  = 2'b10;
  localparam logic [1:0] CELL_HIT   = 2'b11;

  localparam logic [7:0] KEY_W     = 8'h1D;
  localparam logic [7:0] KEY_A     = 8'h1C;
  localparam logic [7:0] KEY_S     = 8'h1B;
  localparam logic [7:0] KEY_D     = 8'h23;
  localparam logic [7:0] KEY_ENTER = 8'h5A;
  localparam logic [7:0] KEY_BREAK = 8'hF0;
  localparam logic [7:0] KEY_EXT   = 8'hE0;

  localparam logic [1:0] RES_NONE   = 2'b00;
  localparam logic [1:0] RES_MISS   = 2'b01;
  localparam logic [1:0] RES_HIT    = 2'b10;
  localparam logic [1:0] RES_REJECT = 2'b11;

  typedef enum logic [2:0] {
    ST_AIM,
    ST_READ,
    ST_EVAL,
    ST_WRITE,
    ST_TURN,
    ST_OVER
  } seq_state_t;

endpackage

// File: rtl/key_cmd_decoder.sv
// Turns raw PS/2 set-2 bytes into single-cycle cursor/fire commands,
// discarding break sequences (F0 xx) and extended prefixes (E0).
module key_cmd_decoder
  import battleship_pkg::*;
(
  input  logic       clock50,
  input  logic       reset_n,
  input  logic       key_valid,
  input  logic [7:0] key_code,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic       fire
);

  logic break_flag;

  always_ff @(posedge clock50 or negedge reset_n) begin
    if (!reset_n) begin
      break_flag <= 1'b0;
    end else if (key_valid) begin
      if (key_code == KEY_BREAK)
        break_flag <= 1'b1;
      else if (key_code != KEY_EXT)
        break_flag <= 1'b0;
    end
  end

  // Commands are combinational so an Enter sampled at edge n launches the read at edge n.
  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    up    = 1'b0;
    down  = 1'b0;
    left  = 1'b0;
    right = 1'b0;
    fire  = 1'b0;
    if (key_valid && !break_flag) begin
      case (key_code)
        KEY_W:     up    = 1'b1;
        KEY_S:     down  = 1'b1;
        KEY_A:     left  = 1'b1;
        KEY_D:     right = 1'b1;
        KEY_ENTER: fire  = 1'b1;
        default:   ;
      endcase
    end
  end

endmodule

// File: rtl/shot_sequencer.sv
// Battleship game-flow controller: aims a cursor from keyboard commands, fires at the
// opponent board through a read/evaluate/write cycle, tallies hits and declares a winner.
module shot_sequencer
  import battleship_pkg::*;
(
  input  logic       clock50,
  input  logic       reset_n,
  input  logic       key_valid,
  input  logic [7:0] key_code,
  output logic [7:0] mem_addr,
  output logic       mem_rd,
  input  logic [1:0] mem_rdata,
  output logic       mem_wr,
  output logic [1:0] mem_wdata,
  output logic [3:0] cursor_row,
  output logic [3:0] cursor_col,
  output logic       player_turn,
  output logic [1:0] shot_result,
  output logic [4:0] hits_p0,
  output logic [4:0] hits_p1,
  output logic       game_over,
  output logic       winner
);

  localparam logic [3:0] LAST_IDX  = 4'(BOARD_SIZE - 1);
  localparam logic [4:0] HIT_LIMIT = 5'(SHIP_CELLS);

  logic       up, down, left, right, fire;
  logic [6:0] cell_idx;
  logic [4:0] shooter_hits;
  seq_state_t state;

  key_cmd_decoder u_key_cmd_decoder (
    .clock50   (clock50),
    .reset_n   (reset_n),
    .key_valid (key_valid),
    .key_code  (key_code),
    .up        (up),
    .down      (down),
    .left      (left),
    .right     (right),
    .fire      (fire)
  );

  // The cursor is frozen outside AIM, so the address holds steady from READ through WRITE.
  assign cell_idx     = 7'(cursor_row * BOARD_SIZE + cursor_col);
  assign mem_addr     = {~player_turn, cell_idx};
  assign shooter_hits = player_turn ? hits_p1 : hits_p0;

  always_ff @(posedge clock50 or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_AIM;
      cursor_row  <= '0;
      cursor_col  <= '0;
      player_turn <= 1'b0;
      shot_result <= RES_NONE;
      hits_p0     <= '0;
      hits_p1     <= '0;
      game_over   <= 1'b0;
      winner      <= 1'b0;
      mem_rd      <= 1'b0;
      mem_wr      <= 1'b0;
      mem_wdata   <= CELL_WATER;
    end else begin
      // NOTE: non-blocking assignments keep every register update tied to the same edge.
      mem_rd <= 1'b0;
      mem_wr <= 1'b0;
      case (state)
        ST_AIM: begin
          if (fire) begin
            mem_rd <= 1'b1;
            state  <= ST_READ;
          end else begin
            if (up && cursor_row != 4'd0)        cursor_row <= cursor_row - 4'd1;
            if (down && cursor_row != LAST_IDX)  cursor_row <= cursor_row + 4'd1;
            if (left && cursor_col != 4'd0)      cursor_col <= cursor_col - 4'd1;
            if (right && cursor_col != LAST_IDX) cursor_col <= cursor_col + 4'd1;
          end
        end
        ST_READ: state <= ST_EVAL;
        ST_EVAL: begin
          case (mem_rdata)
            CELL_WATER: begin
              mem_wdata   <= CELL_MISS;
              shot_result <= RES_MISS;
              mem_wr      <= 1'b1;
              state       <= ST_WRITE;
            end
            CELL_SHIP: begin
              mem_wdata   <= CELL_HIT;
              shot_result <= RES_HIT;
              mem_wr      <= 1'b1;
              state       <= ST_WRITE;
              if (shooter_hits != HIT_LIMIT) begin
                if (player_turn) hits_p1 <= hits_p1 + 5'd1;
                else             hits_p0 <= hits_p0 + 5'd1;
              end
            end
            default: begin
              // Repeat shot on a resolved cell: no write, same shooter aims again.
              shot_result <= RES_REJECT;
              state       <= ST_AIM;
            end
          endcase
        end
        ST_WRITE: state <= ST_TURN;
        ST_TURN: begin
          if (shooter_hits == HIT_LIMIT) begin
            game_over <= 1'b1;
            winner    <= player_turn;
            state     <= ST_OVER;
          end else begin
            player_turn <= ~player_turn;
            state       <= ST_AIM;
          end
        end
        ST_OVER: state <= ST_OVER;
        default: state <= ST_AIM;
      endcase
    end
  end

endmodule
